// File: rtl/pwm_generator.sv
// PWM output stage: compares a free-running period counter against a duty threshold.
// The duty threshold is shadow-loaded only at period boundaries, so the waveform is glitch-free.
module pwm_generator #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             PWM_Enable,
  input  logic [WIDTH-1:0] Register_Data,
  output logic             PWM_Out,
  output logic             Period_Start,
  output logic [WIDTH-1:0] Duty_Active
);

  localparam int unsigned      PsW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0]   PsLast  = PsW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CntMax  = '1;
  // Roughly 20% of full scale (51 for an 8-bit counter).
  localparam logic [WIDTH-1:0] DutyRst = WIDTH'((2 ** WIDTH - 1) / 5);

  typedef enum logic [0:0] {StIdle, StRun} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [PsW-1:0]     ps_q, ps_d;
  logic [WIDTH-1:0]   duty_q, duty_d;
  logic               pwm_q, pwm_d;
  logic               pstart_q, pstart_d;
  logic               tick;

  assign tick = (ps_q == PsLast);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ps_d     = ps_q;
    duty_d   = duty_q;
    pstart_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        count_d = '0;
        ps_d    = '0;
        if (PWM_Enable) begin
          state_d  = StRun;
          duty_d   = Register_Data;
          pstart_d = 1'b1;
        end
      end
      StRun: begin
        if (!PWM_Enable) begin
          // Abandon the current period; a re-enable starts a fresh one.
          state_d = StIdle;
          count_d = '0;
          ps_d    = '0;
        end else if (tick) begin
          ps_d    = '0;
          count_d = count_q + 1'b1;
          if (count_q == CntMax) begin
            duty_d   = Register_Data;
            pstart_d = 1'b1;
          end
        end else begin
          ps_d = ps_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Compare post-edge values so PWM_Out lines up with Period_Start.
    pwm_d = (state_d == StRun) && (count_d < duty_d);
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      ps_q     <= '0;
      duty_q   <= DutyRst;
      pwm_q    <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ps_q     <= ps_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      pstart_q <= pstart_d;
    end
  end

  assign PWM_Out      = pwm_q;
  assign Period_Start = pstart_q;
  assign Duty_Active  = duty_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: two instances (prescale 1 and 4) with a period-level scoreboard.
module tb_pwm_generator;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en0, en4;
  logic [W-1:0] data;
  logic         pwm0, ps0, pwm4, ps4;
  logic [W-1:0] duty0, duty4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int inst;
    int duty;
    int len;
    int hi;
  } rec_t;

  rec_t exp_q[$];

  pwm_generator #(.WIDTH(W), .PRESCALE(1)) u0 (
    .Clock        (clk),
    .Reset_n      (rst_n),
    .PWM_Enable   (en0),
    .Register_Data(data),
    .PWM_Out      (pwm0),
    .Period_Start (ps0),
    .Duty_Active  (duty0)
  );

  pwm_generator #(.WIDTH(W), .PRESCALE(4)) u4 (
    .Clock        (clk),
    .Reset_n      (rst_n),
    .PWM_Enable   (en4),
    .Register_Data(data),
    .PWM_Out      (pwm4),
    .Period_Start (ps4),
    .Duty_Active  (duty4)
  );

  always #5 clk = ~clk;

  // Monitor state per instance.
  bit en_s[2];
  bit in_p[2];
  bit low_seen[2];
  int len_c[2];
  int hi_c[2];
  int ext_c[2];
  int dty_c[2];

  task automatic push(input int inst, input int duty, input int len, input int hi);
    rec_t r;
    r.inst = inst;
    r.duty = duty;
    r.len  = len;
    r.hi   = hi;
    exp_q.push_back(r);
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic finalize(input int id);
    rec_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL period inst%0d: got duty=%0d len=%0d high=%0d, want no period", id,
               dty_c[id], len_c[id], hi_c[id]);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != id || e.duty != dty_c[id] || e.len != len_c[id] || e.hi != hi_c[id] ||
          ext_c[id] != 0) begin
        bad++;
        $display("FAIL period inst%0d: got duty=%0d len=%0d high=%0d late_high=%0d want inst%0d duty=%0d len=%0d high=%0d late_high=0",
                 id, dty_c[id], len_c[id], hi_c[id], ext_c[id], e.inst, e.duty, e.len, e.hi);
      end
    end
  endtask

  task automatic mon_step(input int id, input logic pwm, input logic ps, input logic [W-1:0] duty);
    if (!en_s[id]) begin
      if (in_p[id]) finalize(id);
      in_p[id] = 1'b0;
      total++;
      if (pwm !== 1'b0 || ps !== 1'b0) begin
        bad++;
        $display("FAIL idle_out inst%0d: got pwm=%b start=%b want pwm=0 start=0", id, pwm, ps);
      end
    end else if (ps === 1'b1) begin
      if (in_p[id]) finalize(id);
      in_p[id]     = 1'b1;
      len_c[id]    = 1;
      hi_c[id]     = (pwm === 1'b1) ? 1 : 0;
      ext_c[id]    = 0;
      low_seen[id] = (pwm !== 1'b1);
      dty_c[id]    = int'(duty);
    end else if (in_p[id]) begin
      len_c[id]++;
      if (pwm === 1'b1) begin
        if (low_seen[id]) ext_c[id]++;
        else hi_c[id]++;
      end else begin
        low_seen[id] = 1'b1;
      end
    end else begin
      total++;
      bad++;
      $display("FAIL no_start inst%0d: got running without Period_Start want start pulse", id);
    end
  endtask

  always @(posedge clk) begin
    en_s[0] = (en0 === 1'b1) && (rst_n === 1'b1);
    en_s[1] = (en4 === 1'b1) && (rst_n === 1'b1);
  end

  always @(negedge clk) begin
    mon_step(0, pwm0, ps0, duty0);
    mon_step(1, pwm4, ps4, duty4);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en0   = 1'b1;
    en4   = 1'b0;
    data  = 8'd204;

    // Reset holds defaults regardless of enable and data.
    step(3);
    @(negedge clk);
    check("rst_pwm", int'(pwm0), 0);
    check("rst_start", int'(ps0), 0);
    check("rst_duty0", int'(duty0), 51);
    check("rst_duty4", int'(duty4), 51);
    step(1);
    rst_n = 1'b1;

    push(0, 204, 256, 204);
    push(0, 51, 256, 51);
    push(0, 51, 256, 51);
    push(0, 204, 256, 204);
    push(0, 0, 256, 0);
    push(0, 0, 256, 0);
    push(0, 255, 256, 255);
    push(0, 153, 31, 31);
    push(0, 102, 256, 102);

    step(1);  // E0: first enabled edge
    @(negedge clk);
    check("first_start", int'(ps0), 1);
    check("first_duty", int'(duty0), 204);
    check("first_pwm", int'(pwm0), 1);
    data = 8'd51;
    step(612);  // count=100 of the third period
    data = 8'd204;
    step(156);
    data = 8'd0;
    step(512);
    data = 8'd255;
    step(256);
    data = 8'd153;
    step(286);  // count=30 visible
    en0 = 1'b0;
    step(1);
    @(negedge clk);
    check("drop_pwm", int'(pwm0), 0);
    check("drop_start", int'(ps0), 0);
    data = 8'd102;
    step(1);
    en0 = 1'b1;
    step(1);
    @(negedge clk);
    check("reen_start", int'(ps0), 1);
    check("reen_duty", int'(duty0), 102);
    step(255);
    en0 = 1'b0;
    step(1);

    // Prescaled instance.
    push(1, 102, 1024, 408);
    push(1, 102, 11, 11);
    en4 = 1'b1;
    step(1);
    @(negedge clk);
    check("ps4_start", int'(ps4), 1);
    check("ps4_duty", int'(duty4), 102);
    check("ps4_pwm", int'(pwm4), 1);
    step(1034);
    en4 = 1'b0;
    step(1);

    // Reset in the middle of a period.
    push(0, 77, 21, 21);
    data = 8'd77;
    en0  = 1'b1;
    step(1);
    step(20);
    rst_n = 1'b0;
    step(1);
    @(negedge clk);
    check("midrst_duty", int'(duty0), 51);
    check("midrst_pwm", int'(pwm0), 0);
    check("midrst_start", int'(ps0), 0);
    en0 = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    @(negedge clk);
    check("idle_duty_hold", int'(duty0), 51);
    check("idle_start", int'(ps0), 0);

    step(2);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
PWM output stage of the modulator. It consumes the 8-bit duty threshold produced by the width register and compares it against a free-running period counter to generate the PWM waveform. The duty value is shadow-loaded only at period boundaries, so the waveform is glitch-free. An optional prescaler stretches the period.

Parameters:
WIDTH, 8, counter and duty width in bits; period = 2^WIDTH counter steps.
PRESCALE, 1, clocks per counter step; must be ≥1.

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset_n  input  1  synchronous, active-low reset
PWM_Enable  input  1  1 = run, 0 = idle (output forced low)
Register_Data  input  WIDTH  requested duty threshold from the width register
PWM_Out  output  1  registered PWM waveform
Period_Start  output  1  one-clock pulse marking the first clock of each period
Duty_Active  output  WIDTH  duty value currently applied (shadow register)

Behaviour:
- Reset (Reset_n=0 at an edge) overrides all other inputs:
  - state IDLE; count=0; prescale=0.
  - Duty_Active=51 (20% default); PWM_Out=0; Period_Start=0.
- States: IDLE, RUN. All outputs are registered.
- IDLE:
  - count and prescale held at 0; PWM_Out=0; Period_Start=0; Duty_Active holds its value.
  - Edge with PWM_Enable=1 → RUN. That same edge sets count=0 and prescale=0, loads Duty_Active←Register_Data, sets Period_Start=1, and sets PWM_Out=(0 < loaded duty).
- RUN, each edge with PWM_Enable=1:
  - prescale increments.
  - When prescale==PRESCALE-1 (a tick): prescale←0 and count←count+1, wrapping from 2^WIDTH-1 to 0. With PRESCALE=1, every clock is a tick.
  - On a tick where count wraps to 0: Duty_Active←Register_Data sampled at that edge, and Period_Start=1 for that one clock. Otherwise Period_Start=0.
  - PWM_Out←(new count < new Duty_Active), unsigned compare. The output is evaluated from post-edge values, so it lines up exactly with Period_Start.
- RUN, edge with PWM_Enable=0:
  - → IDLE; count and prescale set to 0; PWM_Out=0 and Period_Start=0 at that edge.
  - A period cut short this way is abandoned, not resumed.
- Register_Data changes mid-period are ignored until the next wrap; there is no immediate update.
- Resulting waveform in steady RUN:
  - period = 2^WIDTH·PRESCALE clocks.
  - PWM_Out high for Duty_Active·PRESCALE clocks from Period_Start, then low for the remainder.
- Duty boundaries:
  - Duty 0 → PWM_Out constantly 0.
  - Duty 2^WIDTH-1 → high for all but the last step; 100% duty is not reachable, by design.
- Reset asserted mid-period returns to IDLE immediately with the reset values above. The first period after reset begins only on an enabled edge.
- No combinational path from any input to any output.

Test Plan:
1. Reset_n=0, PWM_Enable=1, Register_Data=204 for 3 clocks → PWM_Out=0, Period_Start=0, Duty_Active=51. Release reset → Period_Start pulses on the first edge and Duty_Active=204.
2. PRESCALE=1, Register_Data=51, enable held → Period_Start pulses every 256 clocks; PWM_Out high exactly 51 clocks starting with the Period_Start cycle, low 205.
3. Duty at 51, Register_Data changed to 204 while count=100 → the current period stays 51 high. The next Period_Start shows Duty_Active=204 and 204 high clocks.
4. Register_Data=0 → PWM_Out never asserts over 2 periods. Register_Data=255 → 255 high clocks and 1 low clock per period.
5. Duty 153, PWM_Enable dropped at count=30 (output high) → PWM_Out=0 at that edge, Period_Start stays 0. Re-enable with Register_Data=102 → Period_Start on the first enabled edge, fresh period of 102 high / 154 low.
6. PRESCALE=4, Register_Data=102 → period 1024 clocks, PWM_Out high 408 clocks, Period_Start 1 clock wide.
